// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 raster timing and the phase encoding shared by the
// horizontal and vertical sequencers.
package vga_timing_pkg;

   localparam int DEF_DIV      = 4;
   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;

   localparam int H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
   localparam int V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

   typedef enum logic [1:0] {
      PH_ACTIVE = 2'd0,
      PH_FRONT  = 2'd1,
      PH_SYNC   = 2'd2,
      PH_BACK   = 2'd3
   } phase_t;

endpackage

// File: rtl/pixel_tick_gen.sv
// Pixel-rate clock enable: divides original_clk by DIV and emits a registered
// one-cycle strobe; step marks the edge on which the raster should advance.
module pixel_tick_gen #(
   parameter int DIV = 4
) (
   input  logic original_clk,
   input  logic reset,
   input  logic enable,
   output logic pixel_tick,
   output logic step
);

   localparam int CW = $clog2(DIV);

   logic [CW-1:0] div_cnt;

   assign step = enable && (div_cnt == CW'(DIV - 1));

   // While frozen the count holds, so resuming neither loses nor repeats a tick.
   always_ff @(posedge original_clk or posedge reset) begin
      if (reset) begin
         div_cnt    <= '0;
         pixel_tick <= 1'b0;
      end else begin
         pixel_tick <= step;
         if (enable) begin
            div_cnt <= step ? '0 : div_cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA raster sequencer: pixel/line counters, porch/sync phase FSMs and the
// registered sync, blanking and frame-start outputs, all in original_clk.
module vga_timing_ctrl
   import vga_timing_pkg::*;
#(
   parameter int   DIV      = DEF_DIV,
   parameter int   H_ACTIVE = DEF_H_ACTIVE,
   parameter int   H_FP     = DEF_H_FP,
   parameter int   H_SYNC   = DEF_H_SYNC,
   parameter int   H_BP     = DEF_H_BP,
   parameter int   V_ACTIVE = DEF_V_ACTIVE,
   parameter int   V_FP     = DEF_V_FP,
   parameter int   V_SYNC   = DEF_V_SYNC,
   parameter int   V_BP     = DEF_V_BP,
   parameter logic SYNC_POL = 1'b0
) (
   input  logic       original_clk,
   input  logic       reset,
   input  logic       enable,
   output logic       pixel_tick,
   output logic [9:0] pixel_x,
   output logic [9:0] pixel_y,
   output logic       hsync,
   output logic       vsync,
   output logic       video_on,
   output logic       frame_start
);

   localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [9:0] H_MAX      = 10'(HT - 1);
   localparam logic [9:0] V_MAX      = 10'(VT - 1);
   localparam logic [9:0] H_FP_START = 10'(H_ACTIVE);
   localparam logic [9:0] H_SY_START = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] H_BP_START = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] V_FP_START = 10'(V_ACTIVE);
   localparam logic [9:0] V_SY_START = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] V_BP_START = 10'(V_ACTIVE + V_FP + V_SYNC);

   logic       step;
   logic [9:0] x_next;
   logic [9:0] y_next;
   logic       line_wrap;
   logic       frame_wrap;
   phase_t     h_phase;
   phase_t     v_phase;
   phase_t     h_next;
   phase_t     v_next;

   pixel_tick_gen #(
      .DIV (DIV)
   ) u_tick (
      .original_clk (original_clk),
      .reset        (reset),
      .enable       (enable),
      .pixel_tick   (pixel_tick),
      .step         (step)
   );

   // Next raster position and phases, evaluated every cycle but only committed on step.
   always_comb begin
      x_next     = pixel_x + 10'd1;
      y_next     = pixel_y;
      line_wrap  = 1'b0;
      frame_wrap = 1'b0;
      h_next     = h_phase;
      v_next     = v_phase;

      if (pixel_x == H_MAX) begin
         x_next    = '0;
         line_wrap = 1'b1;
         if (pixel_y == V_MAX) begin
            y_next     = '0;
            frame_wrap = 1'b1;
         end else begin
            y_next = pixel_y + 10'd1;
         end
      end

      unique case (h_phase)
         PH_ACTIVE: if (x_next == H_FP_START) h_next = PH_FRONT;
         PH_FRONT:  if (x_next == H_SY_START) h_next = PH_SYNC;
         PH_SYNC:   if (x_next == H_BP_START) h_next = PH_BACK;
         PH_BACK:   if (x_next == 10'd0)      h_next = PH_ACTIVE;
      endcase

      if (line_wrap) begin
         unique case (v_phase)
            PH_ACTIVE: if (y_next == V_FP_START) v_next = PH_FRONT;
            PH_FRONT:  if (y_next == V_SY_START) v_next = PH_SYNC;
            PH_SYNC:   if (y_next == V_BP_START) v_next = PH_BACK;
            PH_BACK:   if (y_next == 10'd0)      v_next = PH_ACTIVE;
         endcase
      end
   end

   // Outputs are decoded from the next phases so they move on the same edge as the counters.
   always_ff @(posedge original_clk or posedge reset) begin
      if (reset) begin
         pixel_x     <= '0;
         pixel_y     <= '0;
         h_phase     <= PH_ACTIVE;
         v_phase     <= PH_ACTIVE;
         hsync       <= ~SYNC_POL;
         vsync       <= ~SYNC_POL;
         video_on    <= 1'b1;
         frame_start <= 1'b0;
      end else begin
         frame_start <= step && frame_wrap;
         if (step) begin
            pixel_x  <= x_next;
            pixel_y  <= y_next;
            h_phase  <= h_next;
            v_phase  <= v_next;
            hsync    <= (h_next == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
            vsync    <= (v_next == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
            video_on <= (h_next == PH_ACTIVE) && (v_next == PH_ACTIVE);
         end
      end
   end

endmodule
